// File: rtl/mem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_pkg : access-size/state types and lane helpers for x_mem_seq
// Rev 1.0
// ------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE     = 2'b00,
    MEM_HALF     = 2'b01,
    MEM_WORD     = 2'b10,
    MEM_WORD_ALT = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SECOND = 2'b01,
    ST_MERGE  = 2'b10
  } seq_state_e;

  function automatic logic [3:0] size_mask(input mem_size_e size);
    case (size)
      MEM_BYTE: return 4'b0001;
      MEM_HALF: return 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input mem_size_e size);
    case (size)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] data, input mem_size_e size,
                                      input logic sgn);
    case (size)
      MEM_BYTE: return {{24{sgn & data[7]}}, data[7:0]};
      MEM_HALF: return {{16{sgn & data[15]}}, data[15:0]};
      default:  return data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_lane_align : byte enables and lane-shifted write data for one beat
// Rev 1.0
// ------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  mem_size_e   size,
  input  logic        beat,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata
);

  logic [7:0]  be_span;
  logic [63:0] data_span;

  // Shift across a two-word window; the upper word is what spills into beat 1.
  always_comb begin
    be_span    = {4'b0000, size_mask(size)} << offset;
    data_span  = {32'h0, wdata} << {offset, 3'b000};
    be         = beat ? be_span[7:4] : be_span[3:0];
    lane_wdata = beat ? data_span[63:32] : data_span[31:0];
  end

endmodule
`default_nettype wire

// File: rtl/x_mem_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// x_mem_seq : execute-stage data-memory sequencer, splits word-crossing accesses
// Rev 1.0
// ------------------------------------------------------------------
module x_mem_seq
  import mem_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        x_mem_req_i,
  input  logic        x_mem_we_i,
  input  logic [1:0]  x_mem_size_i,
  input  logic        x_mem_signed_i,
  input  logic [31:0] x_mem_addr_i,
  input  logic [31:0] x_mem_wdata_i,
  output logic        x_stall_d_o,
  output logic        x_misalign_o,
  output logic        x_rdata_valid_o,
  output logic [31:0] x_rdata_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i
);

  seq_state_e  state, state_next;
  mem_size_e   req_size;
  logic        split;
  logic        issue, issue_split, second, reject;

  logic        lat_we, lat_sgn;
  mem_size_e   lat_size;
  logic [31:0] lat_addr, lat_wdata, beat0_rdata;

  logic        pend_load;
  logic [1:0]  pend_off;
  mem_size_e   pend_size;
  logic        pend_sgn;

  logic [1:0]  lane_off;
  mem_size_e   lane_size;
  logic [31:0] lane_src, lane_wdata;
  logic [3:0]  lane_be;
  logic [31:0] merge_data, single_data;

  assign req_size = mem_size_e'(x_mem_size_i);
  assign split    = ({1'b0, x_mem_addr_i[1:0]} + size_bytes(req_size)) > 3'd4;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  // MERGE only finishes the pending load, so it takes new requests like IDLE.
  always_comb begin
    state_next  = state;
    issue       = 1'b0;
    issue_split = 1'b0;
    second      = 1'b0;
    reject      = 1'b0;
    case (state)
      ST_SECOND: begin
        second     = 1'b1;
        state_next = lat_we ? ST_IDLE : ST_MERGE;
      end
      default: begin
        state_next = ST_IDLE;
        if (x_mem_req_i) begin
          if (!split) begin
            issue = 1'b1;
          end else if (ALLOW_MISALIGNED) begin
            issue       = 1'b1;
            issue_split = 1'b1;
            state_next  = ST_SECOND;
          end else begin
            reject = 1'b1;
          end
        end
      end
    endcase
  end

  assign lane_off  = second ? lat_addr[1:0] : x_mem_addr_i[1:0];
  assign lane_size = second ? lat_size : req_size;
  assign lane_src  = second ? lat_wdata : x_mem_wdata_i;

  mem_lane_align u_lane_align (
    .offset     (lane_off),
    .size       (lane_size),
    .beat       (second),
    .wdata      (lane_src),
    .be         (lane_be),
    .lane_wdata (lane_wdata)
  );

  assign dmem_req_o   = rst_ni & (issue | second);
  assign dmem_we_o    = second ? lat_we : x_mem_we_i;
  assign dmem_addr_o  = second ? {lat_addr[31:2] + 30'd1, 2'b00} : {x_mem_addr_i[31:2], 2'b00};
  assign dmem_be_o    = lane_be;
  assign dmem_wdata_o = lane_wdata;
  assign x_stall_d_o  = rst_ni & issue_split;
  assign x_misalign_o = rst_ni & reject;

  // Beat 1 supplies the high bytes: view {r1, r0} as one 64-bit window.
  assign merge_data  = ext(32'({dmem_rdata_i, beat0_rdata} >> {lat_addr[1:0], 3'b000}),
                           lat_size, lat_sgn);
  assign single_data = ext(dmem_rdata_i >> {pend_off, 3'b000}, pend_size, pend_sgn);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lat_we          <= 1'b0;
      lat_sgn         <= 1'b0;
      lat_size        <= MEM_BYTE;
      lat_addr        <= 32'h0;
      lat_wdata       <= 32'h0;
      beat0_rdata     <= 32'h0;
      pend_load       <= 1'b0;
      pend_off        <= 2'b00;
      pend_size       <= MEM_BYTE;
      pend_sgn        <= 1'b0;
      x_rdata_valid_o <= 1'b0;
      x_rdata_o       <= 32'h0;
    end else begin
      if (issue_split) begin
        lat_we    <= x_mem_we_i;
        lat_sgn   <= x_mem_signed_i;
        lat_size  <= req_size;
        lat_addr  <= x_mem_addr_i;
        lat_wdata <= x_mem_wdata_i;
      end
      if (second) beat0_rdata <= dmem_rdata_i;
      pend_load <= issue & ~issue_split & ~x_mem_we_i;
      if (issue & ~issue_split) begin
        pend_off  <= x_mem_addr_i[1:0];
        pend_size <= req_size;
        pend_sgn  <= x_mem_signed_i;
      end
      x_rdata_valid_o <= pend_load | (state == ST_MERGE);
      if (state == ST_MERGE)  x_rdata_o <= merge_data;
      else if (pend_load)     x_rdata_o <= single_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_x_mem_seq.sv
`default_nettype none
// tb_x_mem_seq : byte-level reference memory, scoreboarded beats and load results
module tb_x_mem_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, req = 1'b0, we = 1'b0, sgn = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0, rdata_mem = 32'h0;

  logic        stall, misalign, rvalid, dreq, dwe;
  logic [31:0] rdata, daddr, dwdata;
  logic [3:0]  dbe;
  logic        na_stall, na_misalign, na_rvalid, na_dreq, na_dwe;
  logic [31:0] na_rdata, na_daddr, na_dwdata;
  logic [3:0]  na_dbe;

  x_mem_seq #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .x_mem_req_i(req), .x_mem_we_i(we),
    .x_mem_size_i(size), .x_mem_signed_i(sgn), .x_mem_addr_i(addr), .x_mem_wdata_i(wdata),
    .x_stall_d_o(stall), .x_misalign_o(misalign), .x_rdata_valid_o(rvalid), .x_rdata_o(rdata),
    .dmem_req_o(dreq), .dmem_we_o(dwe), .dmem_addr_o(daddr), .dmem_be_o(dbe),
    .dmem_wdata_o(dwdata), .dmem_rdata_i(rdata_mem)
  );

  x_mem_seq #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk_i(clk), .rst_ni(rst_n), .x_mem_req_i(req), .x_mem_we_i(we),
    .x_mem_size_i(size), .x_mem_signed_i(sgn), .x_mem_addr_i(addr), .x_mem_wdata_i(wdata),
    .x_stall_d_o(na_stall), .x_misalign_o(na_misalign), .x_rdata_valid_o(na_rvalid),
    .x_rdata_o(na_rdata), .dmem_req_o(na_dreq), .dmem_we_o(na_dwe), .dmem_addr_o(na_daddr),
    .dmem_be_o(na_dbe), .dmem_wdata_o(na_dwdata), .dmem_rdata_i(rdata_mem)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stall;
  } beat_t;
  typedef struct {
    int          cyc;
    logic [31:0] data;
  } res_t;
  beat_t beat_q[$];
  res_t  res_q[$];

  logic [31:0] wmem [logic [31:0]];
  logic [7:0]  bmem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (bmem.exists(a)) return bmem[a];
    w = init_word({a[31:2], 2'b00});
    return 8'(w >> (8 * a[1:0]));
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (wmem.exists(wa)) return wmem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Word-wide memory the DUT talks to; one-cycle read latency.
  logic [31:0] wtmp;
  always @(posedge clk) begin
    if (dreq) begin
      if (dwe) begin
        wtmp = mem_word(daddr);
        for (int b = 0; b < 4; b++) if (dbe[b]) wtmp[8*b +: 8] = dwdata[8*b +: 8];
        wmem[daddr] = wtmp;
      end else begin
        rdata_mem <= mem_word(daddr);
      end
    end
  end

  logic  mon_en = 1'b0;
  beat_t mb;
  res_t  mr;
  logic [31:0] got_wd;
  always @(negedge clk) begin
    if (mon_en) begin
      while (beat_q.size() > 0 && beat_q[0].cyc < cyc) begin
        mb = beat_q.pop_front();
        chk(1'b0, "beat_missing", 96'(cyc), {16'(mb.cyc), mb.addr, mb.wdata});
      end
      while (res_q.size() > 0 && res_q[0].cyc < cyc) begin
        mr = res_q.pop_front();
        chk(1'b0, "result_missing", 96'(cyc), {16'(mr.cyc), mr.data});
      end
      if (dreq) begin
        if (beat_q.size() == 0) begin
          chk(1'b0, "beat_unexpected", {16'(cyc), daddr, dwdata}, 96'h0);
        end else begin
          mb = beat_q.pop_front();
          got_wd = dwe ? (dwdata & be_mask(dbe)) : 32'h0;
          chk(cyc == mb.cyc && dwe == mb.we && daddr == mb.addr && dbe == mb.be &&
              got_wd == mb.wdata && stall == mb.stall, "beat",
              {16'(cyc), 6'h0, dwe, stall, dbe, daddr, got_wd},
              {16'(mb.cyc), 6'h0, mb.we, mb.stall, mb.be, mb.addr, mb.wdata});
        end
      end else begin
        chk(stall == 1'b0, "stall_idle", 96'(stall), 96'h0);
      end
      if (rvalid) begin
        if (res_q.size() == 0) begin
          chk(1'b0, "result_unexpected", {16'(cyc), rdata}, 96'h0);
        end else begin
          mr = res_q.pop_front();
          chk(cyc == mr.cyc && rdata == mr.data, "load_result",
              {16'(cyc), rdata}, {16'(mr.cyc), mr.data});
        end
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic preload(input logic [31:0] wa, input logic [31:0] val);
    wmem[wa] = val;
    for (int b = 0; b < 4; b++) bmem[wa + 32'(b)] = val[8*b +: 8];
  endtask

  // Called just after a rising edge; returns just after the edge that ends the access.
  task automatic issue(input logic w, input logic [1:0] sz, input logic s, input logic [31:0] a,
                       input logic [31:0] wd, input bit rst_mid);
    int n, nb, c;
    logic [31:0] ba, bw, val;
    logic [31:0] wa [2];
    logic [3:0]  bev [2];
    logic [31:0] wdv [2];
    logic [7:0]  by;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    nb = 0; val = 32'h0; c = cyc;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      bw = {ba[31:2], 2'b00};
      if (nb == 0 || wa[nb-1] != bw) begin
        wa[nb] = bw; bev[nb] = 4'h0; wdv[nb] = 32'h0; nb++;
      end
      bev[nb-1][ba[1:0]] = 1'b1;
      by = wd[8*i +: 8];
      wdv[nb-1][8*ba[1:0] +: 8] = by;
      if (w) bmem[ba] = by;
      else   val[8*i +: 8] = ref_byte(ba);
    end
    if (!w && s && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
    for (int k = 0; k < (rst_mid ? 1 : nb); k++)
      beat_q.push_back('{c + k, w, wa[k], bev[k], w ? wdv[k] : 32'h0, (nb == 2 && k == 0)});
    if (!w && !rst_mid) res_q.push_back('{c + nb + 1, val});
    req = 1'b1; we = w; size = sz; sgn = s; addr = a; wdata = wd;
    #1;
    if (nb == 2)
      chk(na_misalign === 1'b1 && na_dreq === 1'b0 && na_stall === 1'b0, "na_reject",
          {93'h0, na_misalign, na_dreq, na_stall}, 96'b100);
    else
      chk(na_misalign === 1'b0 && na_dreq === 1'b1, "na_accept",
          {94'h0, na_misalign, na_dreq}, 96'b01);
    @(posedge clk); #1;
    if (nb == 2) begin
      req = 1'(($urandom) & 1); we = 1'($urandom); size = 2'($urandom);
      addr = $urandom; wdata = $urandom;
      if (rst_mid) begin
        rst_n = 1'b0;
        #1;
        chk(dreq === 1'b0 && stall === 1'b0, "rst_second_quiet", {94'h0, dreq, stall}, 96'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req = 1'b0;
        chk(rvalid === 1'b0 && rdata === 32'h0, "rst_clear", {63'h0, rvalid, rdata}, 96'h0);
      end else begin
        @(posedge clk); #1;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    rst_n = 1'b0;
    idle(3);
    req = 1'b1; size = 2'b10; addr = 32'h0000_0101;
    #1;
    chk(dreq === 1'b0 && stall === 1'b0 && na_misalign === 1'b0, "reset_gating",
        {93'h0, dreq, stall, na_misalign}, 96'h0);
    chk(rvalid === 1'b0 && rdata === 32'h0, "reset_regs", {63'h0, rvalid, rdata}, 96'h0);
    req = 1'b0;
    rst_n = 1'b1;
    idle(1);
    mon_en = 1'b1;

    preload(32'h0000_0100, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    idle(2);
    preload(32'h0000_0100, 32'h80FF_FF00);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0202, 32'hAABB_CCDD, 1'b0);
    preload(32'h0000_0010, 32'h7F00_0000);
    preload(32'h0000_0014, 32'h0000_00FF);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0013, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0202, 32'h0, 1'b0);
    idle(3);
    issue(1'b0, 2'b10, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b1);
    idle(3);

    for (int t = 0; t < 400; t++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) idle(int'($urandom_range(1, 3)));
      a = (r == 1) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : 32'h0000_1000 + $urandom_range(0, 63);
      issue(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, 1'b0);
    end

    idle(6);
    chk(beat_q.size() == 0, "beat_queue_drained", 96'(beat_q.size()), 96'h0);
    chk(res_q.size() == 0, "result_queue_drained", 96'(res_q.size()), 96'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
